uart_encoder: RTL
=================

// Module: uart_encoder
// PURPOSE
//  Bench-side UART transmitter; counterpart to uart_decoder. Queues bytes from
//  the test sequence in a small FIFO and serialises them onto a UART line that
//  drives the DUT's uart0_srx_pad_i, for console-input and loopback testcases.
//  Cycle-based baud timing, so it is also synthesisable for FPGA test harnesses.
// PARAMETERS
//  CLKS_PER_BIT  16  clk cycles per UART bit; legal >= 2
//  DATA_BITS     8   data bits per frame; legal 5..8
//  PARITY        0   0 none, 1 odd, 2 even
//  STOP_BITS     1   1 or 2
//  FIFO_AW       4   FIFO address width; depth = 2**FIFO_AW
// PORTS
//  clk        in   1          clock; all logic on rising edge
//  rst        in   1          synchronous, active-high reset
//  wr_en      in   1          push wr_data into FIFO
//  wr_data    in   8          byte to send; bits above DATA_BITS-1 ignored
//  full       out  1          FIFO full; push ignored while high
//  level      out  FIFO_AW+1  FIFO occupancy 0..2**FIFO_AW
//  overflow   out  1          sticky: push attempted while full (no pop same cycle)
//  busy       out  1          high when frame in progress or FIFO non-empty
//  uart_tx    out  1          serial line, idle high
// BEHAVIOUR
//  - Reset (sync, active-high) values: uart_tx=1, full=0, level=0, overflow=0,
//    busy=0, FSM=IDLE, baud/bit counters=0. Reset mid-frame: line high at the
//    next edge, FIFO flushed, partial frame discarded.
//  - FIFO: push when wr_en && (!full || pop same cycle); occupancy registered.
//    Pop happens on the IDLE->START transition only. Push+pop same cycle:
//    level unchanged, both take effect. Pointers wrap mod 2**FIFO_AW.
//  - FSM: IDLE -> START -> DATA -> [PARITY if PARITY!=0] -> STOP -> IDLE/START.
//    IDLE: uart_tx=1; if FIFO non-empty, pop head into shift reg, go START.
//    START: uart_tx=0 for CLKS_PER_BIT cycles.
//    DATA: DATA_BITS bits, LSB first, each CLKS_PER_BIT cycles.
//    PARITY: odd/even over the DATA_BITS sent bits, CLKS_PER_BIT cycles.
//    STOP: uart_tx=1 for STOP_BITS*CLKS_PER_BIT cycles; on final cycle, if FIFO
//    non-empty pop and enter START directly (no idle gap), else go IDLE.
//  - Latency: push at edge N into empty FIFO while IDLE -> FSM leaves IDLE at
//    edge N+1; uart_tx falls after edge N+1 (one cycle write-to-line latency).
//  - Frame length = (1+DATA_BITS+(PARITY?1:0)+STOP_BITS)*CLKS_PER_BIT cycles
//    exactly; back-to-back frames abut with no extra cycles.
//  - uart_tx is a register output (no combinational glitch on the line).
//  - overflow clears only on rst. busy = (FSM!=IDLE) || (level!=0).
// TESTING
//  1 CLKS_PER_BIT=4, push 0x55 -> uart_tx: 0 then 1,0,1,0,1,0,1,0 then 1, each
//    level 4 cycles; falls 1 cycle after push; busy drops after 40 cycles.
//  2 Push 0x41,0x42,0x43 in 3 consecutive cycles -> three 40-cycle frames back
//    to back, no idle gap; uart_decoder at matching period prints "ABC".
//  3 FIFO_AW=2: push 5 bytes while frame 0 running -> 4 accepted... full=1
//    after 4th queued, 5th sets overflow=1; push in the cycle of a pop accepted.
//  4 PARITY=2, DATA_BITS=7, STOP_BITS=2, push 0x07 -> data 1,1,1,0,0,0,0,
//    parity 1, two stop bits; frame = 11*CLKS_PER_BIT cycles.
//  5 Assert rst mid-DATA of a frame with 2 bytes queued -> uart_tx=1 next
//    cycle, level=0, busy=0, overflow=0; no further frames emitted.
//  6 Loopback in orpsoc bench: drive DUT rx with "hello\n" -> DUT echo test
//    returns identical string via uart_decoder before timeout.

Source files
------------

// File: rtl/uart_encoder.sv
// rtl/uart_encoder.sv - FIFO-buffered UART transmitter with cycle-based baud timing
// Bytes queue in a small FIFO and are framed as start/data/[parity]/stop on uart_tx.
module uart_encoder #(
  parameter int CLKS_PER_BIT = 16,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1,
  parameter int FIFO_AW      = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [7:0]       wr_data,
  output logic             full,
  output logic [FIFO_AW:0] level,
  output logic             overflow,
  output logic             busy,
  output logic             uart_tx
);

  localparam int DEPTH = 2 ** FIFO_AW;
  localparam int CW    = $clog2(STOP_BITS * CLKS_PER_BIT + 1);
  localparam logic [7:0]    DMASK     = 8'((1 << DATA_BITS) - 1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] STOP_LAST = CW'(STOP_BITS * CLKS_PER_BIT - 1);
  localparam logic [3:0]    DATA_LAST = 4'(DATA_BITS - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_t;

  state_t               state;
  logic [CW-1:0]        baud_cnt;
  logic [3:0]           bit_cnt;
  logic [7:0]           shift;
  logic                 par_bit;
  logic [7:0]           mem [DEPTH];
  logic [FIFO_AW-1:0]   wr_ptr;
  logic [FIFO_AW-1:0]   rd_ptr;
  logic                 pop;
  logic                 push;
  logic [7:0]           head;
  logic                 head_par;

  // Pop only when a frame may start: from IDLE, or on the last STOP cycle so frames abut.
  assign head     = mem[rd_ptr] & DMASK;
  assign head_par = (PARITY == 1) ? ~^head : ^head;
  assign full     = (level == (FIFO_AW + 1)'(DEPTH));
  assign pop      = (level != '0) &&
                    ((state == IDLE) || ((state == STOP) && (baud_cnt == STOP_LAST)));
  assign push     = wr_en && (!full || pop);
  assign busy     = (state != IDLE) || (level != '0);

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      level <= level + 1'b1;
      else if (pop && !push) level <= level - 1'b1;
      if (wr_en && !push) overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      shift    <= '0;
      par_bit  <= 1'b0;
      uart_tx  <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          uart_tx <= 1'b1;
          if (pop) begin
            shift    <= head;
            par_bit  <= head_par;
            baud_cnt <= '0;
            uart_tx  <= 1'b0;
            state    <= START;
          end
        end
        START: begin
          if (baud_cnt == BIT_LAST) begin
            baud_cnt <= '0;
            bit_cnt  <= '0;
            uart_tx  <= shift[0];
            state    <= DATA;
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        DATA: begin
          if (baud_cnt == BIT_LAST) begin
            baud_cnt <= '0;
            if (bit_cnt == DATA_LAST) begin
              if (PARITY != 0) begin
                uart_tx <= par_bit;
                state   <= PAR;
              end else begin
                uart_tx <= 1'b1;
                state   <= STOP;
              end
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
              shift   <= shift >> 1;
              uart_tx <= shift[1];
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        PAR: begin
          if (baud_cnt == BIT_LAST) begin
            baud_cnt <= '0;
            uart_tx  <= 1'b1;
            state    <= STOP;
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        STOP: begin
          if (baud_cnt == STOP_LAST) begin
            baud_cnt <= '0;
            if (pop) begin
              shift   <= head;
              par_bit <= head_par;
              uart_tx <= 1'b0;
              state   <= START;
            end else begin
              state <= IDLE;
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        default: begin
          uart_tx <= 1'b1;
          state   <= IDLE;
        end
      endcase
    end
  end

endmodule
